idelay_tap_calib: RTL and testbench

IDELAY_TAP_CALIB -- requirements
Module: idelay_tap_calib

---
 rtl/tap_calib_pkg.sv | 34 +++
 rtl/tap_err_counter.sv | 26 ++
 rtl/idelay_tap_calib.sv | 231 +++++++++++++++++++++++
 tb/tb_idelay_tap_calib.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tap_calib_pkg.sv
// Shared definitions for the IDELAY tap calibration block: widths, tap count,
// the sweep state encoding and the helper that picks the centre of a run.
package tap_calib_pkg;

  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 32;
  localparam int ERR_W    = 16;
  localparam int RUN_W    = 6;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_RDY,
    LOAD,
    SETTLE,
    MEASURE,
    EVAL,
    CENTER,
    CSETTLE,
    FINISH
  } calib_state_t;

  // Centre of a good-tap run, rounding towards the start of the run; an empty
  // run maps to tap 0 so a failed sweep parks the delay line at its minimum.
  function automatic logic [TAP_W-1:0] centerTap(input logic [TAP_W-1:0] runStart,
                                                 input logic [RUN_W-1:0] runLen);
    logic [RUN_W-1:0] half;
    half = (runLen - RUN_W'(1)) >> 1;
    if (runLen == '0) begin
      return '0;
    end
    return runStart + half[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/tap_err_counter.sv
// Saturating mismatch counter used to score one tap setting.
module tap_err_counter
  import tap_calib_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             mismatch_i,
  output logic [ERR_W-1:0] count_o
);

  logic [ERR_W-1:0] count_q;

  // Count enabled mismatching cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (enable_i && mismatch_i && (count_q != '1)) begin
      count_q <= count_q + ERR_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/idelay_tap_calib.sv
// IDELAYE2 tap sweep: scores every tap against a fixed reference path, keeps
// the longest run of clean taps and loads its centre.
// Optional feature macro: TAP_CALIB_TRACK_EN (background re-measure while locked).
module idelay_tap_calib
  import tap_calib_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int MEAS_CYCLES   = 1024,
  parameter int ERR_THRESH    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             idelay_rdy,
  input  logic [7:0]       sample_window,
  output logic [TAP_W-1:0] tap_value,
  output logic             tap_load,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic [TAP_W-1:0] best_tap,
  output logic [RUN_W-1:0] win_width
);

  localparam int CNT_MAX = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYCLES - 1);
  localparam logic [ERR_W-1:0] THRESH      = ERR_W'(ERR_THRESH);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);

  calib_state_t     state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] runStart_q, runStart_d;
  logic [RUN_W-1:0] runLen_q, runLen_d;
  logic [TAP_W-1:0] bestStart_q, bestStart_d;
  logic [RUN_W-1:0] bestLen_q, bestLen_d;
  logic [TAP_W-1:0] bestTap_q, bestTap_d;
  logic [RUN_W-1:0] winWidth_q, winWidth_d;
  logic             locked_q, locked_d;

  logic [ERR_W-1:0] errCnt;
  logic             mismatch;
  logic             tapGood;
  logic [TAP_W-1:0] candStart, bestStartNew;
  logic [RUN_W-1:0] candLen, bestLenNew;
  logic             trackActive, trackLast, trackFail;
  logic             cntClear, cntEnable;

  assign mismatch = (sample_window[7:4] != sample_window[3:0]);

`ifdef TAP_CALIB_TRACK_EN
  assign trackActive = (state_q == IDLE) && locked_q && !start;
`else
  assign trackActive = 1'b0;
`endif

  // The last window cycle's own sample is folded in so the tracking window is
  // exactly MEAS_CYCLES long even though the counter is cleared at its end.
  assign trackLast = trackActive && (cnt_q == MEAS_LAST);
  assign trackFail = trackLast &&
                     ((errCnt > THRESH) || (mismatch && (errCnt == THRESH)));

  assign cntEnable = (state_q == MEASURE) || trackActive;
  assign cntClear  = !((state_q == MEASURE) || (trackActive && !trackLast));

  tap_err_counter u_err_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cntClear),
    .enable_i  (cntEnable),
    .mismatch_i(mismatch),
    .count_o   (errCnt)
  );

  // Extend or close the current run with this tap's score, and promote it to
  // best only when strictly longer so equal later runs never displace earlier ones.
  always_comb begin
    tapGood      = (errCnt <= THRESH);
    candStart    = runStart_q;
    candLen      = '0;
    if (tapGood) begin
      candLen   = runLen_q + RUN_W'(1);
      candStart = (runLen_q == '0) ? tap_q : runStart_q;
    end
    bestStartNew = bestStart_q;
    bestLenNew   = bestLen_q;
    if (candLen > bestLen_q) begin
      bestStartNew = candStart;
      bestLenNew   = candLen;
    end
  end

  // Sweep sequencing: next state plus every tracker and result register.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    cnt_d       = cnt_q;
    runStart_d  = runStart_q;
    runLen_d    = runLen_q;
    bestStart_d = bestStart_q;
    bestLen_d   = bestLen_q;
    bestTap_d   = bestTap_q;
    winWidth_d  = winWidth_q;
    locked_d    = locked_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WAIT_RDY;
          locked_d = 1'b0;
          cnt_d    = '0;
        end else if (trackActive) begin
          cnt_d = trackLast ? '0 : cnt_q + CNT_W'(1);
          if (trackFail) begin
            locked_d = 1'b0;
            state_d  = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (idelay_rdy) begin
          state_d     = LOAD;
          tap_d       = '0;
          cnt_d       = '0;
          runStart_d  = '0;
          runLen_d    = '0;
          bestStart_d = '0;
          bestLen_d   = '0;
        end
      end
      LOAD: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (cnt_q == MEAS_LAST) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EVAL: begin
        runStart_d  = candStart;
        runLen_d    = candLen;
        bestStart_d = bestStartNew;
        bestLen_d   = bestLenNew;
        if (tap_q != LAST_TAP) begin
          state_d = LOAD;
          tap_d   = tap_q + TAP_W'(1);
        end else begin
          state_d    = CENTER;
          tap_d      = centerTap(bestStartNew, bestLenNew);
          bestTap_d  = centerTap(bestStartNew, bestLenNew);
          winWidth_d = bestLenNew;
        end
      end
      CENTER: begin
        state_d = CSETTLE;
        cnt_d   = '0;
      end
      CSETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        state_d  = IDLE;
        cnt_d    = '0;
        locked_d = (winWidth_q != '0);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q inside {LOAD, SETTLE, MEASURE, EVAL, CENTER, CSETTLE}) && !idelay_rdy) begin
      state_d = WAIT_RDY;
      cnt_d   = '0;
    end
  end

  // State and tracker registers with synchronous reset to the idle, unlocked state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      cnt_q       <= '0;
      runStart_q  <= '0;
      runLen_q    <= '0;
      bestStart_q <= '0;
      bestLen_q   <= '0;
      bestTap_q   <= '0;
      winWidth_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      cnt_q       <= cnt_d;
      runStart_q  <= runStart_d;
      runLen_q    <= runLen_d;
      bestStart_q <= bestStart_d;
      bestLen_q   <= bestLen_d;
      bestTap_q   <= bestTap_d;
      winWidth_q  <= winWidth_d;
      locked_q    <= locked_d;
    end
  end

  assign tap_value = tap_q;
  assign tap_load  = (state_q == LOAD) || (state_q == CENTER);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign locked    = locked_q;
  assign best_tap  = bestTap_q;
  assign win_width = winWidth_q;

endmodule

// File: tb/tb_idelay_tap_calib.sv
// Self-checking bench for idelay_tap_calib with short settle/measure windows.
module tb_idelay_tap_calib;

  localparam int S   = 4;
  localparam int M   = 16;
  localparam int LAT = 32 * (S + M + 2) + S + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       idelay_rdy;
  logic [7:0] sample_window;
  logic [4:0] tap_value;
  logic       tap_load;
  logic       busy;
  logic       done;
  logic       locked;
  logic [4:0] best_tap;
  logic [5:0] win_width;

  always #5 clk = ~clk;

  idelay_tap_calib #(
    .SETTLE_CYCLES(S),
    .MEAS_CYCLES  (M),
    .ERR_THRESH   (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .idelay_rdy   (idelay_rdy),
    .sample_window(sample_window),
    .tap_value    (tap_value),
    .tap_load     (tap_load),
    .busy         (busy),
    .done         (done),
    .locked       (locked),
    .best_tap     (best_tap),
    .win_width    (win_width)
  );

  typedef struct {
    logic [31:0] mask;
    logic [4:0]  expTap;
    logic [5:0]  expWidth;
    logic        expLocked;
    int          expLoads;
  } vec_t;

  vec_t        vecs[7];
  vec_t        sbQ[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] goodMask = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance one clock, then present the sample pattern for the tap now on tap_value:
  // matching nibbles for a good tap, differing nibbles for a bad one.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    sample_window = goodMask[tap_value] ? 8'hAA : 8'h5A;
  endtask

  task automatic applyStimulus(input vec_t v, input bit injectStart, input bit dropRdy);
    vec_t       e;
    int         loads     = 0;
    int         firstLoad = -1;
    int         doneCycle = -1;
    int         dropAt    = -1;
    bit         armed     = 1'b1;
    logic [4:0] lastLoad  = '0;
    goodMask      = v.mask;
    sample_window = goodMask[tap_value] ? 8'hAA : 8'h5A;
    sbQ.push_back(v);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    for (int cyc = 1; cyc <= 3 * LAT; cyc++) begin
      stepCycle();
      start = 1'b0;
      if (tap_load) begin
        loads++;
        lastLoad = tap_value;
        if (armed) begin
          firstLoad = cyc;
          armed     = 1'b0;
          checkOutput("first_load_tap", 32'(tap_value), 32'd0);
        end
        if (dropRdy && (dropAt < 0) && (tap_value == 5'd7)) begin
          dropAt = cyc + 3;
        end
      end
      if (done) begin
        doneCycle = cyc;
        break;
      end
      if (injectStart && (cyc == 200)) begin
        checkOutput("busy_mid_sweep", 32'(busy), 32'd1);
        start = 1'b1;
      end
      if (dropRdy && (cyc == dropAt)) begin
        idelay_rdy = 1'b0;
      end
      if (dropRdy && (dropAt > 0) && (cyc == dropAt + 3)) begin
        idelay_rdy = 1'b1;
        armed      = 1'b1;
      end
    end
    start      = 1'b0;
    idelay_rdy = 1'b1;
    checkOutput("done_seen", 32'(doneCycle >= 0), 32'd1);
    e = sbQ.pop_front();
    checkOutput("best_tap", 32'(best_tap), 32'(e.expTap));
    checkOutput("win_width", 32'(win_width), 32'(e.expWidth));
    checkOutput("load_count", 32'(loads), 32'(e.expLoads));
    checkOutput("final_load_value", 32'(lastLoad), 32'(e.expTap));
    checkOutput("latency", 32'(doneCycle - firstLoad + 1), 32'(LAT));
    stepCycle();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("locked", 32'(locked), 32'(e.expLocked));
    checkOutput("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{mask: 32'h001F_FFE0, expTap: 5'd12, expWidth: 6'd16, expLocked: 1'b1, expLoads: 33};
    vecs[1] = '{mask: 32'h0000_1C1C, expTap: 5'd3,  expWidth: 6'd3,  expLocked: 1'b1, expLoads: 33};
    vecs[2] = '{mask: 32'hF000_0000, expTap: 5'd29, expWidth: 6'd4,  expLocked: 1'b1, expLoads: 33};
    vecs[3] = '{mask: 32'h0000_0000, expTap: 5'd0,  expWidth: 6'd0,  expLocked: 1'b0, expLoads: 33};
    vecs[4] = '{mask: 32'hFFFF_FFFF, expTap: 5'd15, expWidth: 6'd32, expLocked: 1'b1, expLoads: 33};
    vecs[5] = '{mask: 32'h8000_0000, expTap: 5'd31, expWidth: 6'd1,  expLocked: 1'b1, expLoads: 33};
    vecs[6] = '{mask: 32'h0000_0001, expTap: 5'd0,  expWidth: 6'd1,  expLocked: 1'b1, expLoads: 33};

    rst           = 1'b1;
    start         = 1'b0;
    idelay_rdy    = 1'b1;
    sample_window = 8'h00;
    stepCycle();
    stepCycle();
    checkOutput("rst_tap_value", 32'(tap_value), 32'd0);
    checkOutput("rst_tap_load", 32'(tap_load), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_best_tap", 32'(best_tap), 32'd0);
    checkOutput("rst_win_width", 32'(win_width), 32'd0);
    rst = 1'b0;
    stepCycle();

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d mask=%h", i, vecs[i].mask);
      applyStimulus(vecs[i], 1'b0, 1'b0);
    end

    $display("[TB] start pulse while busy");
    applyStimulus(vecs[0], 1'b1, 1'b0);

    $display("[TB] idelay_rdy drop during tap 7");
    applyStimulus('{mask: 32'h001F_FFE0, expTap: 5'd12, expWidth: 6'd16,
                    expLocked: 1'b1, expLoads: 41}, 1'b0, 1'b1);

    $display("[TB] reset during MEASURE");
    goodMask = vecs[0].mask;
    start    = 1'b1;
    stepCycle();
    start = 1'b0;
    cnt   = 0;
    while (!(tap_load && (tap_value == 5'd2)) && (cnt < 500)) begin
      stepCycle();
      cnt++;
    end
    checkOutput("reach_tap2", 32'(cnt < 500), 32'd1);
    for (int i = 0; i < S + 2; i++) begin
      stepCycle();
    end
    rst = 1'b1;
    stepCycle();
    checkOutput("midrst_tap_value", 32'(tap_value), 32'd0);
    checkOutput("midrst_tap_load", 32'(tap_load), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_best_tap", 32'(best_tap), 32'd0);
    checkOutput("midrst_win_width", 32'(win_width), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (done || busy) cnt++;
    end
    checkOutput("midrst_no_done", 32'(cnt), 32'd0);

    $display("[TB] recovery sweep after reset");
    applyStimulus(vecs[1], 1'b0, 1'b0);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
